golomb_codeword_serializer: RTL and testbench
=============================================

Name: golomb_codeword_serializer

Overview:
- Downstream neighbour of the prediction-residual stage in the JPEG-LS regular-mode path.
- Accepts one modulo-reduced signed residual plus Golomb parameter k per codeword.
- Maps the residual to the non-negative MErrval and emits the limited-length Golomb-Rice codeword MSB-first, one bit per cycle, over a valid/ready serial interface.
- Feeds the bit packer.

Parameters:
- residual_length, 9, width of two's-complement residual input.
- k_length, 4, width of Golomb parameter k (legal k 0..8).
- qbpp, 8, escape suffix width (bits per pixel).
- LIMIT, 32, maximum codeword length; escape threshold = LIMIT-qbpp-1 = 23.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  residual/k/map_invert valid.
- in_ready  output  1  block can accept a codeword.
- residual  input  residual_length  signed Errval, range -128..127.
- k  input  k_length  Golomb parameter.
- map_invert  input  1  special mapping (k==0 && 2B<=-N), computed upstream.
- bit_valid  output  1  bit_out valid.
- bit_ready  input  1  downstream accepts bit.
- bit_out  output  1  current code bit.
- bit_last  output  1  final bit of current codeword.

Behaviour:
- Reset (async, immediate): state=IDLE, in_ready=1, bit_valid=0, bit_out=0, bit_last=0, all internal counters and registers 0.
- Mapping, registered on accept:
  - map_invert=0: MErrval = 2*Errval if Errval>=0, else -2*Errval-1.
  - map_invert=1: MErrval = 2*Errval+1 if Errval>=0, else -2*(Errval+1).
  - MErrval is 8 bits unsigned, q = MErrval>>k.
- Accept: in_valid && in_ready at edge t. The first bit is presented with bit_valid=1 after edge t; no combinational in->out path.
- FSM states:
  - IDLE: in_ready=1, bit_valid=0. Accept -> UNARY if q>0 or escape, otherwise -> STOP.
  - UNARY: bit_out=0. Emits min(q,23) zeros, tracked by a 5-bit down-counter. Last zero -> STOP.
  - STOP: bit_out=1. Next state -> SUFFIX if suffix length>0, otherwise -> IDLE.
  - SUFFIX: emits the suffix MSB-first via a shift register, then -> IDLE.
- Normal code (q<23): q zeros, '1', then k LSBs of MErrval. Length q+1+k.
- Escape code (q>=23): 23 zeros, '1', then qbpp bits of MErrval-1. Length exactly 32.
- A bit is consumed only on bit_valid && bit_ready. While bit_ready=0, bit_out, bit_last and the state hold stable.
- bit_last=1 only on the final bit of the codeword (STOP when the suffix is empty, or the last SUFFIX bit).
- Back-to-back codewords:
  - in_ready is also asserted during the final bit, with in_ready = (state==IDLE) || (bit_valid && bit_last && bit_ready).
  - Simultaneous last-bit consume and accept loads the new codeword with no bubble.
- k>8: illegal input. Behaviour is unspecified but must not hang; the suffix counter saturates at 8.
- q=22 is a normal code; q=23 is an escape code (exact boundary).

Optional Feature:
- Macro GOLOMB_BIT_COUNT_EN.
- Defined:
  - Adds output bit_count (32 bits), reset to 0.
  - Increments on every consumed bit and wraps modulo 2^32.
  - Adds output code_len (6 bits), registered at accept with the full codeword length.
- Undefined: neither port exists and there is no counter logic. Serial behaviour is identical in both builds.

Test Plan:
- residual=+3, k=1, map_invert=0 -> MErrval=6, bits 0,0,0,1,0; bit_last on bit 5; in_ready high during bit 5.
- residual=-3, k=2 -> MErrval=5, bits 0,1,0,1. Then residual=0, k=0, map_invert=1 -> MErrval=1, bits 0,1, issued back-to-back with no idle cycle.
- residual=-128, k=0 -> MErrval=255, escape: 23 zeros, 1, 11111110 (32 bits). With GOLOMB_BIT_COUNT_EN, code_len=32.
- Boundary: residual=11, k=0 (MErrval=22) -> 22 zeros + 1 (23 bits). residual=-12, k=0 (MErrval=23) -> 32-bit escape with suffix 00010110.
- Hold bit_ready=0 for 3 cycles on the 2nd bit of the residual=+3, k=1 code -> bit_out, bit_last and the state stay stable. After release, the remaining bits match the first scenario.
- Assert reset during UNARY of the escape codeword -> bit_valid=0 and in_ready=1 immediately. The next codeword (+3, k=1) serialises correctly with no residue of the aborted one.

Source files
------------

// File: rtl/golomb_codeword_serializer.sv
// JPEG-LS limited-length Golomb-Rice codeword serializer: maps Errval to MErrval, emits code MSB-first.
// Optional GOLOMB_BIT_COUNT_EN adds a running consumed-bit counter and per-codeword length output.
module golomb_codeword_serializer #(
    parameter int residual_length = 9,
    parameter int k_length        = 4,
    parameter int qbpp            = 8,
    parameter int LIMIT           = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [residual_length-1:0] residual,
    input  logic [k_length-1:0]        k,
    input  logic                       map_invert,
    output logic                       bit_valid,
    input  logic                       bit_ready,
    output logic                       bit_out,
    output logic                       bit_last
`ifdef GOLOMB_BIT_COUNT_EN
    ,
    output logic [31:0]                bit_count,
    output logic [5:0]                 code_len
`endif
);
    localparam int MW = residual_length + 2;
    localparam int ESC = LIMIT - qbpp - 1;
    localparam logic [qbpp-1:0] ESC_Q  = qbpp'(ESC);
    localparam logic [4:0]      ESC_Z  = 5'(ESC);
    localparam logic [3:0]      SFX_MAX = 4'(qbpp);

    typedef enum logic [1:0] {IDLE, UNARY, STOP, SUFFIX} state_t;
    state_t state;

    logic [4:0]      zcnt;
    logic [3:0]      sfx_cnt;
    logic [qbpp-1:0] sfx_sh;

    logic signed [MW-1:0] r_ext, two_r, base, m_full;
    logic [qbpp-1:0] merr, q, sfx_val, sfx_aligned;
    logic            escape;
    logic [4:0]      unary_len;
    logic [3:0]      sfx_len;
    logic            acc, cons;

    // -x-1 == ~x, so both negative mappings reduce to an inversion of the positive form.
    always_comb begin
        r_ext       = {{2{residual[residual_length-1]}}, residual};
        two_r       = r_ext <<< 1;
        base        = map_invert ? {two_r[MW-1:1], 1'b1} : two_r;
        m_full      = residual[residual_length-1] ? ~base : base;
        merr        = m_full[qbpp-1:0];
        q           = merr >> k;
        escape      = (q >= ESC_Q);
        unary_len   = escape ? ESC_Z : q[4:0];
        sfx_len     = escape ? SFX_MAX : ((k > k_length'(qbpp)) ? SFX_MAX : 4'(k));
        sfx_val     = escape ? (merr - qbpp'(1)) : merr;
        sfx_aligned = sfx_val << (SFX_MAX - sfx_len);
    end

    assign cons     = bit_valid && bit_ready;
    assign in_ready = (state == IDLE) || (bit_valid && bit_last && bit_ready);
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            bit_last  <= 1'b0;
            zcnt      <= '0;
            sfx_cnt   <= '0;
            sfx_sh    <= '0;
        end else if (acc) begin
            // Accept wins over the final-bit retire so back-to-back codewords have no bubble.
            bit_valid <= 1'b1;
            zcnt      <= unary_len;
            sfx_cnt   <= sfx_len;
            sfx_sh    <= sfx_aligned;
            if (unary_len != 5'd0) begin
                state    <= UNARY;
                bit_out  <= 1'b0;
                bit_last <= 1'b0;
            end else begin
                state    <= STOP;
                bit_out  <= 1'b1;
                bit_last <= (sfx_len == 4'd0);
            end
        end else if (cons) begin
            case (state)
                UNARY: begin
                    if (zcnt == 5'd1) begin
                        state    <= STOP;
                        bit_out  <= 1'b1;
                        bit_last <= (sfx_cnt == 4'd0);
                    end
                    zcnt <= zcnt - 5'd1;
                end
                STOP, SUFFIX: begin
                    if (sfx_cnt != 4'd0) begin
                        state    <= SUFFIX;
                        bit_out  <= sfx_sh[qbpp-1];
                        bit_last <= (sfx_cnt == 4'd1);
                        sfx_sh   <= sfx_sh << 1;
                        sfx_cnt  <= sfx_cnt - 4'd1;
                    end else begin
                        state     <= IDLE;
                        bit_valid <= 1'b0;
                        bit_out   <= 1'b0;
                        bit_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GOLOMB_BIT_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count <= '0;
            code_len  <= '0;
        end else begin
            if (cons)
                bit_count <= bit_count + 32'd1;
            if (acc)
                code_len <= escape ? 6'(LIMIT) : (6'(q) + 6'd1 + 6'(sfx_len));
        end
    end
`endif
endmodule

// File: tb/tb_golomb_codeword_serializer.sv
// Scoreboard bench: driver pushes hand-computed code bits at accept, monitor pops on each consumed bit.
module tb_golomb_codeword_serializer;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, map_invert;
    logic [8:0] residual;
    logic [3:0] k;
    logic       bit_valid, bit_ready, bit_out, bit_last;
`ifdef GOLOMB_BIT_COUNT_EN
    logic [31:0] bit_count;
    logic [5:0]  code_len;
`endif

    golomb_codeword_serializer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .residual(residual), .k(k), .map_invert(map_invert),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out), .bit_last(bit_last)
`ifdef GOLOMB_BIT_COUNT_EN
        , .bit_count(bit_count), .code_len(code_len)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       b;
        bit       last;
        bit       first;
        int       clen;
    } exp_bit_t;
    exp_bit_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    // residual, k, map_invert, codeword length, codeword (right-aligned, MSB sent first)
    int          V_RES [9] = '{3, -3, 0, -128, 11, -12, 0, 100, 5};
    int          V_K   [9] = '{1, 2, 0, 0, 0, 0, 0, 8, 1};
    int          V_INV [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    int          V_LEN [9] = '{5, 4, 2, 32, 23, 32, 1, 9, 7};
    logic [31:0] V_CODE[9] = '{32'h2, 32'h5, 32'h1, 32'h1FE, 32'h1, 32'h116, 32'h1, 32'h1C8, 32'h3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int i);
        bit acc = 0;
        int n = 0;
        residual   = 9'(V_RES[i]);
        k          = 4'(V_K[i]);
        map_invert = V_INV[i][0];
        in_valid   = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                for (int j = V_LEN[i] - 1; j >= 0; j--) begin
                    exp_bit_t e;
                    logic [31:0] c;
                    c       = V_CODE[i];
                    e.b     = c[j];
                    e.last  = (j == 0);
                    e.first = (j == V_LEN[i] - 1);
                    e.clen  = V_LEN[i];
                    sb.push_back(e);
                end
            end
            n++;
            if (n > 200 && !acc) begin
                chk("accept_timeout", 32'(n), 32'd0);
                acc = 1;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: bit_valid must track scoreboard occupancy; held bits must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            chk("bit_valid", {31'd0, bit_valid}, {31'd0, sb.size() > 0});
            if (bit_valid && sb.size() > 0) begin
                chk("bit_out", {31'd0, bit_out}, {31'd0, sb[0].b});
                chk("bit_last", {31'd0, bit_last}, {31'd0, sb[0].last});
`ifdef GOLOMB_BIT_COUNT_EN
                if (sb[0].first)
                    chk("code_len", {26'd0, code_len}, 32'(sb[0].clen));
`endif
                if (bit_ready) begin
                    chk("in_ready", {31'd0, in_ready}, {31'd0, sb[0].last});
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; residual = '0; k = '0; map_invert = 1'b0; bit_ready = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
        chk("rst_bit_last", {31'd0, bit_last}, 32'd0);
`ifdef GOLOMB_BIT_COUNT_EN
        chk("rst_bit_count", bit_count, 32'd0);
`endif
        @(posedge clk); #1 reset = 1'b0;

        send(0); drain();
        for (int i = 1; i < 9; i++) send(i);
        drain();

        // stall on the second bit of +3,k=1
        send(0);
        @(posedge clk); #1 bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bit_ready = 1'b1;
        drain();

        // abort an escape codeword mid-unary
        send(3);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        #1;
        chk("abort_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        send(0); drain();
`ifdef GOLOMB_BIT_COUNT_EN
        chk("bit_count", bit_count, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
